syn_fifo_reader: RTL and testbench

Read-side consumer for syn_fifo. It pops words from the FIFO read port, which has 1-cycle read latency, and presents them on a valid/ready stream. A 2-entry skid buffer gives full throughput under back-pressure. It also supports a flush that drains and discards FIFO contents, and keeps a running count of delivered words. It sits between syn_fifo and any downstream stream consumer, on the same single clock.

---
 rtl/syn_fifo_reader_if.sv | 41 ++++
 rtl/syn_fifo_reader.sv | 152 +++++++++++++++
 tb/tb_syn_fifo_reader.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/syn_fifo_reader_if.sv
// Bundle of FIFO read-port, stream and status signals for syn_fifo_reader.
// FIFO_READER_HOLD_EN adds the hold_i pause input.
interface syn_fifo_reader_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CNT_WIDTH  = 16
);
    logic                  fifo_empty_i;
    logic                  half_full_i;
    logic [DATA_WIDTH-1:0] fifo_rdata_i;
    logic                  fifo_rd_o;
    logic                  m_valid_o;
    logic [DATA_WIDTH-1:0] m_data_o;
    logic                  m_ready_i;
    logic                  flush_i;
    logic                  busy_o;
    logic [CNT_WIDTH-1:0]  word_cnt_o;
    logic                  underflow_o;
`ifdef FIFO_READER_HOLD_EN
    logic                  hold_i;

    modport master (
        input  fifo_empty_i, half_full_i, fifo_rdata_i, m_ready_i, flush_i, hold_i,
        output fifo_rd_o, m_valid_o, m_data_o, busy_o, word_cnt_o, underflow_o
    );

    modport slave (
        output fifo_empty_i, half_full_i, fifo_rdata_i, m_ready_i, flush_i, hold_i,
        input  fifo_rd_o, m_valid_o, m_data_o, busy_o, word_cnt_o, underflow_o
    );
`else
    modport master (
        input  fifo_empty_i, half_full_i, fifo_rdata_i, m_ready_i, flush_i,
        output fifo_rd_o, m_valid_o, m_data_o, busy_o, word_cnt_o, underflow_o
    );

    modport slave (
        output fifo_empty_i, half_full_i, fifo_rdata_i, m_ready_i, flush_i,
        input  fifo_rd_o, m_valid_o, m_data_o, busy_o, word_cnt_o, underflow_o
    );
`endif
endinterface

// File: rtl/syn_fifo_reader.sv
// Read-side consumer for syn_fifo: 1-cycle-latency pops into a 2-entry skid buffer feeding a
// valid/ready stream, with flush and delivered-word counter. FIFO_READER_HOLD_EN adds hold_i.
module syn_fifo_reader #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic               sys_clk_i,
    input  logic               sys_rst_ni,
    syn_fifo_reader_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nxt;

    logic [1:0]            occ;
    logic                  inflight;
    logic [DATA_WIDTH-1:0] head;
    logic [DATA_WIDTH-1:0] tail;
    logic [CNT_WIDTH-1:0]  word_cnt;
    logic                  underflow;

    logic                  rd;
    logic                  pop;
    logic                  capture;
    logic                  flush_take;
    logic                  hold;
    logic [1:0]            credit_used;

`ifdef FIFO_READER_HOLD_EN
    assign hold = bus.hold_i;
`else
    assign hold = 1'b0;
`endif

    logic unused_status;
    assign unused_status = bus.half_full_i;

    always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
        if (!sys_rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.flush_i) begin
                    state_nxt = FLUSH;
                end else if (!bus.fifo_empty_i) begin
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                if (bus.flush_i) begin
                    state_nxt = FLUSH;
                end else if (bus.fifo_empty_i && (occ == 2'd0) && !inflight) begin
                    state_nxt = IDLE;
                end
            end
            FLUSH: begin
                if (bus.fifo_empty_i && !inflight) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A pop in the same cycle frees a slot before the read data lands, so the credit check
    // counts it; without that the buffer could only sustain one word every other cycle.
    always_comb begin
        flush_take  = bus.flush_i && (state != FLUSH);
        pop         = (occ != 2'd0) && bus.m_ready_i && !flush_take;
        capture     = inflight && (state != FLUSH) && !flush_take;
        credit_used = occ + {1'b0, inflight};
        rd          = 1'b0;
        case (state)
            FETCH: rd = !bus.fifo_empty_i && !hold &&
                        ((credit_used < 2'd2) || (pop && (credit_used == 2'd2)));
            FLUSH: rd = !bus.fifo_empty_i;
            default: rd = 1'b0;
        endcase
    end

    always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
        if (!sys_rst_ni) begin
            occ  <= 2'd0;
            head <= '0;
            tail <= '0;
        end else if (flush_take || (state == FLUSH)) begin
            occ <= 2'd0;
        end else begin
            case ({capture, pop})
                2'b10: begin
                    if (occ == 2'd0) begin
                        head <= bus.fifo_rdata_i;
                        occ  <= 2'd1;
                    end else begin
                        tail <= bus.fifo_rdata_i;
                        occ  <= 2'd2;
                    end
                end
                2'b01: begin
                    head <= tail;
                    occ  <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        head <= bus.fifo_rdata_i;
                    end else begin
                        head <= tail;
                        tail <= bus.fifo_rdata_i;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
        if (!sys_rst_ni) begin
            inflight  <= 1'b0;
            word_cnt  <= '0;
            underflow <= 1'b0;
        end else begin
            inflight <= rd;
            if (pop) begin
                word_cnt <= word_cnt + 1'b1;
            end
            if (rd && bus.fifo_empty_i) begin
                underflow <= 1'b1;
            end
        end
    end

    assign bus.fifo_rd_o   = rd;
    assign bus.m_valid_o   = (occ != 2'd0);
    assign bus.m_data_o    = head;
    assign bus.busy_o      = (state != IDLE);
    assign bus.word_cnt_o  = word_cnt;
    assign bus.underflow_o = underflow;

endmodule

// File: tb/tb_syn_fifo_reader.sv
// Directed bench for syn_fifo_reader against a simple 1-cycle-latency FIFO model.
// A second instance with a 4-bit counter shares the same stimulus for the wrap check.
module tb_syn_fifo_reader;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    syn_fifo_reader_if #(.DATA_WIDTH(8), .CNT_WIDTH(16)) bus ();
    syn_fifo_reader_if #(.DATA_WIDTH(8), .CNT_WIDTH(4))  bus4 ();

    syn_fifo_reader #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
        .sys_clk_i (clk),
        .sys_rst_ni(rst_n),
        .bus       (bus.master)
    );

    syn_fifo_reader #(.DATA_WIDTH(8), .CNT_WIDTH(4)) dut4 (
        .sys_clk_i (clk),
        .sys_rst_ni(rst_n),
        .bus       (bus4.master)
    );

    logic [7:0]  mem [0:63];
    int unsigned wr_ptr     = 0;
    int unsigned rd_ptr     = 0;
    logic        rand_mode  = 1'b1;
    logic        rand_empty = 1'b0;
    logic        ready      = 1'b0;
    logic        flush      = 1'b0;

    int compared   = 0;
    int mismatched = 0;

    logic       bp_rd [1:11] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic       bp_v  [1:11] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [7:0] bp_d  [1:11] = '{8'h00, 8'h00, 8'hA0, 8'hA0, 8'hA1, 8'hA1,
                                 8'hA2, 8'hA2, 8'hA3, 8'hA3, 8'h00};

    assign bus.fifo_empty_i = rand_mode ? rand_empty : (wr_ptr == rd_ptr);
    assign bus.half_full_i  = ((wr_ptr - rd_ptr) >= 8);
    assign bus.m_ready_i    = ready;
    assign bus.flush_i      = flush;

    assign bus4.fifo_empty_i = bus.fifo_empty_i;
    assign bus4.half_full_i  = bus.half_full_i;
    assign bus4.fifo_rdata_i = bus.fifo_rdata_i;
    assign bus4.m_ready_i    = bus.m_ready_i;
    assign bus4.flush_i      = bus.flush_i;

`ifdef FIFO_READER_HOLD_EN
    logic hold = 1'b0;
    assign bus.hold_i  = hold;
    assign bus4.hold_i = hold;
`endif

    always @(posedge clk) begin
        if (bus.fifo_rd_o && (wr_ptr != rd_ptr)) begin
            bus.fifo_rdata_i <= mem[rd_ptr[5:0]];
            rd_ptr           <= rd_ptr + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        mem[wr_ptr[5:0]] = d;
        wr_ptr = wr_ptr + 1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // reset held with random inputs
        for (int i = 0; i < 4; i++) begin
            step();
            rand_empty = 1'($urandom_range(0, 1));
            ready      = 1'($urandom_range(0, 1));
            flush      = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("rst_rd",    bus.fifo_rd_o,   0);
            chk("rst_valid", bus.m_valid_o,   0);
            chk("rst_data",  bus.m_data_o,    0);
            chk("rst_busy",  bus.busy_o,      0);
            chk("rst_cnt",   bus.word_cnt_o,  0);
            chk("rst_uf",    bus.underflow_o, 0);
        end
        step();
        rand_mode = 1'b0;
        flush     = 1'b0;
        ready     = 1'b0;
        rst_n     = 1'b1;
        @(negedge clk);
        chk("rel_busy", bus.busy_o, 0);
        chk("rel_rd",   bus.fifo_rd_o, 0);
        step();
        @(negedge clk);
        chk("rel_idle_rd", bus.fifo_rd_o, 0);

        // streaming 0x00..0x0F at full rate
        step();
        for (int i = 0; i < 16; i++) push(8'(i));
        ready = 1'b1;
        @(negedge clk);
        chk("str_c0_rd",   bus.fifo_rd_o, 0);
        step(); @(negedge clk);
        chk("str_c1_rd",   bus.fifo_rd_o, 1);
        chk("str_c1_valid", bus.m_valid_o, 0);
        chk("str_c1_busy", bus.busy_o, 1);
        step(); @(negedge clk);
        chk("str_c2_valid", bus.m_valid_o, 0);
        chk("str_c2_rd",    bus.fifo_rd_o, 1);
        for (int k = 0; k < 16; k++) begin
            step(); @(negedge clk);
            chk("str_valid", bus.m_valid_o, 1);
            chk("str_data",  bus.m_data_o, 32'(k));
        end
        step(); @(negedge clk);
        chk("str_end_valid", bus.m_valid_o, 0);
        chk("str_cnt",       bus.word_cnt_o, 16);
        step(); @(negedge clk);
        chk("str_idle", bus.busy_o, 0);

        // back-pressure: ready toggles 0/1, starting low
        step();
        for (int i = 0; i < 4; i++) push(8'hA0 + 8'(i));
        ready = 1'b0;
        @(negedge clk);
        chk("bp_c0_rd", bus.fifo_rd_o, 0);
        for (int k = 1; k <= 11; k++) begin
            step();
            ready = ((k % 2) == 0);
            @(negedge clk);
            chk("bp_rd",    bus.fifo_rd_o, 32'(bp_rd[k]));
            chk("bp_valid", bus.m_valid_o, 32'(bp_v[k]));
            if (bp_v[k]) chk("bp_data", bus.m_data_o, 32'(bp_d[k]));
        end
        chk("bp_cnt", bus.word_cnt_o, 20);
        step(); @(negedge clk);
        chk("bp_idle", bus.busy_o, 0);

        // flush after two deliveries
        step();
        for (int i = 0; i < 8; i++) push(8'hB0 + 8'(i));
        ready = 1'b1;
        @(negedge clk);
        chk("fl_c0_rd", bus.fifo_rd_o, 0);
        step(); @(negedge clk);
        chk("fl_c1_rd", bus.fifo_rd_o, 1);
        step(); @(negedge clk);
        step(); @(negedge clk);
        chk("fl_c3_data", bus.m_data_o, 8'hB0);
        step(); @(negedge clk);
        chk("fl_c4_data", bus.m_data_o, 8'hB1);
        step();
        ready = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        chk("fl_c5_valid", bus.m_valid_o, 1);
        chk("fl_c5_data",  bus.m_data_o, 8'hB2);
        chk("fl_c5_rd",    bus.fifo_rd_o, 0);
        step();
        flush = 1'b0;
        @(negedge clk);
        chk("fl_c6_valid", bus.m_valid_o, 0);
        chk("fl_c6_rd",    bus.fifo_rd_o, 1);
        chk("fl_c6_busy",  bus.busy_o, 1);
        chk("fl_c6_cnt",   bus.word_cnt_o, 22);
        for (int k = 7; k <= 9; k++) begin
            step(); @(negedge clk);
            chk("fl_drain_rd",    bus.fifo_rd_o, 1);
            chk("fl_drain_valid", bus.m_valid_o, 0);
        end
        step(); @(negedge clk);
        chk("fl_c10_rd",   bus.fifo_rd_o, 0);
        chk("fl_c10_busy", bus.busy_o, 1);
        step(); @(negedge clk);
        chk("fl_c11_busy", bus.busy_o, 1);
        step(); @(negedge clk);
        chk("fl_c12_busy",  bus.busy_o, 0);
        chk("fl_cnt",       bus.word_cnt_o, 22);
        chk("fl_fifo_empty", (wr_ptr == rd_ptr), 1);

        // counter wrap: 18 words, 4-bit counter ends at 2
        step();
        rst_n = 1'b0;
        @(negedge clk);
        chk("wr_rst_cnt4", bus4.word_cnt_o, 0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 18; i++) push(8'h40 + 8'(i));
        ready = 1'b1;
        for (int i = 0; i < 24; i++) step();
        @(negedge clk);
        chk("wr_busy", bus.busy_o, 0);
        chk("wr_cnt16", bus.word_cnt_o, 18);
        chk("wr_cnt4",  bus4.word_cnt_o, 2);

        // random empty toggling
        step();
        rand_mode = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            step();
            rand_empty = 1'($urandom_range(0, 1));
            ready      = 1'($urandom_range(0, 1));
            flush      = ($urandom_range(0, 15) == 0);
            @(negedge clk);
            chk("rnd_rd_empty", 32'(bus.fifo_rd_o & bus.fifo_empty_i), 0);
        end
        chk("rnd_uf",  bus.underflow_o, 0);
        chk("rnd_uf4", bus4.underflow_o, 0);
        step();
        rand_mode = 1'b0;
        flush     = 1'b0;
        rst_n     = 1'b0;
        step();
        rst_n = 1'b1;

`ifdef FIFO_READER_HOLD_EN
        // hold pauses consumption so the fill level can rise
        hold  = 1'b1;
        ready = 1'b1;
        for (int i = 0; i < 4; i++) push(8'h60 + 8'(i));
        @(negedge clk);
        chk("hd_hf_low", bus.half_full_i, 0);
        for (int i = 0; i < 10; i++) begin
            step();
            if (i == 4) begin
                for (int j = 4; j < 12; j++) push(8'h60 + 8'(j));
            end
            @(negedge clk);
            chk("hd_rd",    bus.fifo_rd_o, 0);
            chk("hd_valid", bus.m_valid_o, 0);
        end
        chk("hd_hf_high", bus.half_full_i, 1);
        step();
        hold = 1'b0;
        for (int i = 0; i < 22; i++) step();
        @(negedge clk);
        chk("hd_busy", bus.busy_o, 0);
        chk("hd_cnt",  bus.word_cnt_o, 12);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
